hp48_bus: RTL and testbench

//  Nibble-wide system bus controller for the Saturn core; sits between saturn_core and memory.

---
 rtl/hp48_bus_pkg.sv | 28 ++
 rtl/hp48_nibble_mem.sv | 27 ++
 rtl/hp48_bus.sv | 137 +++++++++++++
 tb/tb_hp48_bus.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hp48_bus_pkg.sv
// Shared bus definitions for hp48_bus and saturn_core: command encodings,
// bus widths and the read-source selector used by the output mux.
package hp48_bus_pkg;

  localparam int ADDR_W = 20;
  localparam int NIB_W  = 4;

  localparam logic [3:0] BUSCMD_NOP       = 4'h0;
  localparam logic [3:0] BUSCMD_PC_READ   = 4'h1;
  localparam logic [3:0] BUSCMD_DP_READ   = 4'h2;
  localparam logic [3:0] BUSCMD_DP_WRITE  = 4'h3;
  localparam logic [3:0] BUSCMD_LOAD_PC   = 4'h4;
  localparam logic [3:0] BUSCMD_LOAD_DP   = 4'h5;
  localparam logic [3:0] BUSCMD_CONFIGURE = 4'h6;
  localparam logic [3:0] BUSCMD_RESET     = 4'h7;

  // Which source drives nibble_out since the last read command.
  typedef enum logic [1:0] {
    RD_ZERO,
    RD_ROM,
    RD_RAM
  } rd_src_e;

  function automatic logic cmd_illegal(input logic [3:0] cmd);
    return cmd[3];
  endfunction

endpackage

// File: rtl/hp48_nibble_mem.sv
// Synchronous one-read/one-write nibble array; WRITABLE=0 turns it into a ROM.
// INIT_FILE names the intended preload image; contents are supplied externally.
module hp48_nibble_mem
  import hp48_bus_pkg::*;
#(
  parameter int    AW        = 16,
  parameter string INIT_FILE = "",
  parameter bit    WRITABLE  = 1'b1
) (
  input  logic             strobe,
  input  logic             re,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [NIB_W-1:0] wdata,
  output logic [NIB_W-1:0] rdata
);

  logic [NIB_W-1:0] mem [0:(1<<AW)-1];

  // NOTE: the array and its read register have no reset; memory contents must
  // survive a bus reset, and the top masks rdata until a read has happened.
  always_ff @(posedge strobe) begin
    if (WRITABLE && we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/hp48_bus.sv
// Saturn nibble bus controller: PC/DP pointers, ROM at 00000, relocatable RAM,
// sticky bus_error. Define HP48_BUS_TRACE_EN for a per-command $display trace.
module hp48_bus
  import hp48_bus_pkg::*;
#(
  parameter int    ROM_AW   = 19,
  parameter string ROM_FILE = "hp48_rom.hex",
  parameter int    RAM_AW   = 16
) (
  input  logic              strobe,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [3:0]        command,
  input  logic [NIB_W-1:0]  nibble_in,
  output logic [NIB_W-1:0]  nibble_out,
  output logic              bus_error
);

  logic [ADDR_W-1:0]        pc_ptr;
  logic [ADDR_W-1:0]        dp_ptr;
  logic [ADDR_W-RAM_AW-1:0] ram_page;
  logic                     ram_cfg;
  rd_src_e                  rd_src;

  logic [ADDR_W-1:0] acc_addr;
  logic              is_read;
  logic              is_write;
  logic              hit_ram;
  logic              hit_rom;
  logic              acc_err;
  logic              rom_re;
  logic              ram_re;
  logic              ram_we;
  logic [NIB_W-1:0]  rom_rdata;
  logic [NIB_W-1:0]  ram_rdata;

  // Decode of the access this edge; RAM wins over ROM where they overlap.
  always_comb begin
    is_read  = (command == BUSCMD_PC_READ) || (command == BUSCMD_DP_READ);
    is_write = (command == BUSCMD_DP_WRITE);
    acc_addr = (command == BUSCMD_PC_READ) ? pc_ptr : dp_ptr;
    hit_ram  = ram_cfg && (acc_addr[ADDR_W-1:RAM_AW] == ram_page);
    hit_rom  = (acc_addr >> ROM_AW) == '0;
    acc_err  = cmd_illegal(command)
             || (is_read && !hit_ram && !hit_rom)
             || (is_write && !hit_ram);
    rom_re   = !reset && is_read && !hit_ram && hit_rom;
    ram_re   = !reset && is_read && hit_ram;
    ram_we   = !reset && is_write && hit_ram;
  end

  hp48_nibble_mem #(
    .AW       (ROM_AW),
    .INIT_FILE(ROM_FILE),
    .WRITABLE (1'b0)
  ) u_rom (
    .strobe(strobe),
    .re    (rom_re),
    .we    (1'b0),
    .addr  (acc_addr[ROM_AW-1:0]),
    .wdata ('0),
    .rdata (rom_rdata)
  );

  hp48_nibble_mem #(
    .AW       (RAM_AW),
    .INIT_FILE(""),
    .WRITABLE (1'b1)
  ) u_ram (
    .strobe(strobe),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (acc_addr[RAM_AW-1:0]),
    .wdata (nibble_in),
    .rdata (ram_rdata)
  );

  // NOTE: state registers use non-blocking assignments so every update in this
  // block sees the pre-edge values of pc_ptr/dp_ptr.
  always_ff @(posedge strobe or posedge reset) begin
    if (reset) begin
      pc_ptr    <= '0;
      dp_ptr    <= '0;
      ram_page  <= '0;
      ram_cfg   <= 1'b0;
      rd_src    <= RD_ZERO;
      bus_error <= 1'b0;
    end else begin
      if (acc_err) bus_error <= 1'b1;
      case (command)
        BUSCMD_LOAD_PC: pc_ptr <= address;
        BUSCMD_LOAD_DP: dp_ptr <= address;
        BUSCMD_PC_READ: begin
          pc_ptr <= pc_ptr + 1'b1;
          rd_src <= hit_ram ? RD_RAM : (hit_rom ? RD_ROM : RD_ZERO);
        end
        BUSCMD_DP_READ: begin
          dp_ptr <= dp_ptr + 1'b1;
          rd_src <= hit_ram ? RD_RAM : (hit_rom ? RD_ROM : RD_ZERO);
        end
        BUSCMD_DP_WRITE: dp_ptr <= dp_ptr + 1'b1;
        BUSCMD_CONFIGURE: begin
          ram_page <= address[ADDR_W-1:RAM_AW];
          ram_cfg  <= 1'b1;
        end
        BUSCMD_RESET: ram_cfg <= 1'b0;
        default: ;
      endcase
    end
  end

  // NOTE: nibble_out gets its default before the case so no latch is inferred.
  always_comb begin
    nibble_out = '0;
    case (rd_src)
      RD_ROM:  nibble_out = rom_rdata;
      RD_RAM:  nibble_out = ram_rdata;
      default: ;
    endcase
  end

`ifdef HP48_BUS_TRACE_EN
  always @(posedge strobe) begin
    if (!reset && command != BUSCMD_NOP) begin
      $display("hp48_bus: cmd=%0h address=%05h ptr=%05h nibble_in=%0h",
               command, address, acc_addr, nibble_in);
      if (acc_err)
        $display("hp48_bus: BUS ERROR cmd=%0h ptr=%05h cause=%s", command, acc_addr,
                 cmd_illegal(command) ? "illegal command" :
                 is_write ? "write outside RAM" : "read of unmapped address");
    end
  end
`else
  // Trace disabled: this build carries no simulation-only statements.
`endif

endmodule

// File: tb/tb_hp48_bus.sv
// Self-checking bench for hp48_bus: directed scenarios with literal
// expectations, then randomized traffic against a behavioural bus model.
module tb_hp48_bus;

  localparam int ROM_AW   = 19;
  localparam int RAM_AW   = 16;
  localparam int ROM_SIZE = 1 << ROM_AW;
  localparam int RAM_SIZE = 1 << RAM_AW;
  localparam int unsigned AMASK = 32'hFFFFF;

  localparam logic [3:0] C_NOP  = 4'h0;
  localparam logic [3:0] C_PCR  = 4'h1;
  localparam logic [3:0] C_DPR  = 4'h2;
  localparam logic [3:0] C_WR   = 4'h3;
  localparam logic [3:0] C_LDPC = 4'h4;
  localparam logic [3:0] C_LDDP = 4'h5;
  localparam logic [3:0] C_CFG  = 4'h6;
  localparam logic [3:0] C_RST  = 4'h7;

  logic        strobe = 1'b0;
  logic        reset  = 1'b1;
  logic [19:0] address = '0;
  logic [3:0]  command = C_NOP;
  logic [3:0]  nibble_in = '0;
  logic [3:0]  nibble_out;
  logic        bus_error;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  // Behavioural model state
  logic [3:0]  rom_img [0:ROM_SIZE-1];
  logic [3:0]  m_ram [int unsigned];
  int unsigned m_pc, m_dp, m_base;
  bit          m_cfg, m_err, m_known;
  logic [3:0]  m_out;

  hp48_bus #(
    .ROM_AW  (ROM_AW),
    .ROM_FILE(""),
    .RAM_AW  (RAM_AW)
  ) dut (
    .strobe    (strobe),
    .reset     (reset),
    .address   (address),
    .command   (command),
    .nibble_in (nibble_in),
    .nibble_out(nibble_out),
    .bus_error (bus_error)
  );

  always #5 strobe = ~strobe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_ram(input int unsigned a);
    return m_cfg && (a / RAM_SIZE) == (m_base / RAM_SIZE);
  endfunction

  task automatic model_reset();
    m_pc = 0; m_dp = 0; m_cfg = 0; m_err = 0; m_out = 4'h0; m_known = 1;
  endtask

  task automatic model_read(input int unsigned a);
    if (in_ram(a)) begin
      if (m_ram.exists(a % RAM_SIZE)) begin
        m_out = m_ram[a % RAM_SIZE];
        m_known = 1;
      end else begin
        m_known = 0;
      end
    end else if (a < ROM_SIZE) begin
      m_out = rom_img[a];
      m_known = 1;
    end else begin
      m_out = 4'h0;
      m_known = 1;
      m_err = 1;
    end
  endtask

  task automatic model_step(input logic [3:0] c, input logic [19:0] a, input logic [3:0] n);
    case (c)
      C_NOP: ;
      C_PCR: begin model_read(m_pc); m_pc = (m_pc + 1) & AMASK; end
      C_DPR: begin model_read(m_dp); m_dp = (m_dp + 1) & AMASK; end
      C_WR: begin
        if (in_ram(m_dp)) m_ram[m_dp % RAM_SIZE] = n;
        else m_err = 1;
        m_dp = (m_dp + 1) & AMASK;
      end
      C_LDPC: m_pc = a;
      C_LDDP: m_dp = a;
      C_CFG:  begin m_base = a - (a % RAM_SIZE); m_cfg = 1; end
      C_RST:  m_cfg = 0;
      default: m_err = 1;
    endcase
  endtask

  // One bus command: drive on the falling edge, model the rising edge, settle.
  task automatic step(input logic [3:0] c, input logic [19:0] a = '0, input logic [3:0] n = '0);
    @(negedge strobe);
    command = c; address = a; nibble_in = n;
    @(posedge strobe);
    if (!reset) model_step(c, a, n);
    #1;
  endtask

  // Asynchronous reset between edges; commands issued while it is high must be ignored.
  task automatic do_reset();
    @(negedge strobe);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("reset_nibble_out", nibble_out, 4'h0);
    check("reset_bus_error", bus_error, 1'b0);
    step(C_LDPC, 20'h00005);
    step(4'hC);
    step(C_CFG, 20'h00000);
    @(negedge strobe);
    reset = 1'b0;
    command = C_NOP;
  endtask

  always @(negedge strobe) begin
    if (cmp_en) begin
      if (m_known) check("cmp_nibble_out", nibble_out, m_out);
      check("cmp_bus_error", bus_error, m_err);
    end
  end

  function automatic logic [19:0] pick_addr();
    case ($urandom_range(0, 4))
      0:       return 20'(32'h7FFF0 + $urandom_range(0, 31));
      1:       return 20'((m_base + RAM_SIZE - 8 + $urandom_range(0, 15)) & AMASK);
      2:       return 20'(32'hFFFF8 + $urandom_range(0, 7));
      3:       return 20'($urandom_range(0, 31));
      default: return 20'($urandom & AMASK);
    endcase
  endfunction

  function automatic logic [19:0] pick_base();
    case ($urandom_range(0, 4))
      0:       return 20'h00000;
      1:       return 20'h70000;
      2:       return 20'h80000;
      3:       return 20'hF0000;
      default: return 20'($urandom & AMASK);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    for (int i = 0; i < ROM_SIZE; i++) begin
      rom_img[i] = (i < 16) ? 4'(i) : 4'($urandom);
      dut.u_rom.mem[i] = rom_img[i];
    end
    model_reset();
    m_base = 0;
    #1;
    check("por_nibble_out", nibble_out, 4'h0);
    check("por_bus_error", bus_error, 1'b0);
    @(negedge strobe);
    reset = 1'b0;
    cmp_en = 1'b1;

    // ROM sequential fetch
    step(C_LDPC, 20'h00000);
    step(C_PCR); check("rom_rd0", nibble_out, 4'h0);
    step(C_PCR); check("rom_rd1", nibble_out, 4'h1);
    step(C_PCR); check("rom_rd2", nibble_out, 4'h2);
    step(C_PCR); check("rom_pc_at_3", nibble_out, 4'h3);
    check("rom_no_err", bus_error, 1'b0);

    // RAM write / readback at 80000
    step(C_CFG, 20'h80000);
    step(C_LDDP, 20'h80010);
    step(C_WR, 20'h0, 4'hA);
    step(C_WR, 20'h0, 4'h5);
    step(C_LDDP, 20'h80010);
    step(C_DPR); check("ram_rd_a", nibble_out, 4'hA);
    step(C_DPR); check("ram_rd_5", nibble_out, 4'h5);
    check("ram_no_err", bus_error, 1'b0);

    // Write to ROM is dropped and flags a sticky error
    step(C_LDDP, 20'h00004);
    step(C_WR, 20'h0, 4'h9);
    check("rom_wr_err", bus_error, 1'b1);
    for (int i = 0; i < 3; i++) step(C_NOP);
    check("err_sticky", bus_error, 1'b1);
    step(C_LDPC, 20'h00004);
    step(C_PCR); check("rom_unchanged", nibble_out, 4'h4);

    // Reset mid-stream, then fetch restarts at 00000
    do_reset();
    step(C_PCR); check("post_rst_rd0", nibble_out, 4'h0);
    step(C_PCR); check("post_rst_rd1", nibble_out, 4'h1);
    check("post_rst_err", bus_error, 1'b0);

    // RESET command unmaps RAM
    step(C_CFG, 20'h80000);
    step(C_LDDP, 20'h80010);
    step(C_DPR); check("ram_kept", nibble_out, 4'hA);
    step(C_RST);
    step(C_LDDP, 20'h80010);
    step(C_DPR); check("unmapped_rd", nibble_out, 4'h0);
    check("unmapped_err", bus_error, 1'b1);
    do_reset();

    // Top-of-space wrap with RAM at F0000
    step(C_CFG, 20'hF0000);
    step(C_LDDP, 20'hFFFFF);
    step(C_WR, 20'h0, 4'h7);
    step(C_LDPC, 20'hFFFFF);
    step(C_PCR); check("wrap_ram_ffff", nibble_out, 4'h7);
    step(C_PCR); check("wrap_rom_0", nibble_out, 4'h0);
    check("wrap_no_err", bus_error, 1'b0);
    step(4'hC); check("illegal_err", bus_error, 1'b1);
    do_reset();

    // RAM overrides ROM where they overlap
    step(C_CFG, 20'h00000);
    step(C_LDDP, 20'h00002);
    step(C_WR, 20'h0, 4'hE);
    step(C_LDPC, 20'h00002);
    step(C_PCR); check("overlap_ram", nibble_out, 4'hE);
    check("overlap_no_err", bus_error, 1'b0);
    do_reset();

    // Randomized traffic, checked every cycle by the compare process
    for (int s = 0; s < 4000; s++) begin
      if (s % 250 == 249) do_reset();
      r = $urandom_range(0, 99);
      if      (r < 20) step(C_PCR);
      else if (r < 40) step(C_DPR);
      else if (r < 58) step(C_WR, 20'h0, 4'($urandom));
      else if (r < 68) step(C_LDPC, pick_addr());
      else if (r < 78) step(C_LDDP, pick_addr());
      else if (r < 83) step(C_CFG, pick_base());
      else if (r < 86) step(C_RST);
      else if (r < 98) step(C_NOP, pick_addr(), 4'($urandom));
      else             step(4'(8 + $urandom_range(0, 7)));
    end

    step(C_NOP);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
